// File: rtl/int_seq_if.sv
// -----------------------------------------------------------------------------
// int_seq_if
// Bundles the signals that int_seq exchanges with its neighbours:
//   - peripheral data bus : din, addr, we (in)   / dout (out)
//   - interrupt controller: int_vld, int_num (in) / int_rdy (out)
//   - processor core      : irq_ack, reti (in)   / irq_req, irq_vec (out)
// modport slave  : the sequencer's view (int_seq).
// modport master : the environment's view (controller, core, bus master).
// Parameters DW/AW must match the ones given to int_seq.
// -----------------------------------------------------------------------------
interface int_seq_if #(
   parameter int DW = 16,
   parameter int AW = 13
) ();

   logic [DW-1:0] din;
   logic [AW-1:0] addr;
   logic          we;
   logic [DW-1:0] dout;
   logic          int_vld;
   logic [2:0]    int_num;
   logic          int_rdy;
   logic          irq_req;
   logic [AW-1:0] irq_vec;
   logic          irq_ack;
   logic          reti;

   modport master (
      output din, addr, we, int_vld, int_num, irq_ack, reti,
      input  dout, int_rdy, irq_req, irq_vec
   );

   modport slave (
      input  din, addr, we, int_vld, int_num, irq_ack, reti,
      output dout, int_rdy, irq_req, irq_vec
   );

endinterface

// File: rtl/int_seq.sv
// -----------------------------------------------------------------------------
// int_seq
// Interrupt entry sequencer. Takes one interrupt at a time from the interrupt
// controller (int_vld/int_num, acknowledged through int_rdy), raises a
// vectored request to the core and then refuses further interrupts until the
// handler has returned (reti) and a programmable guard gap has elapsed.
// A software interrupt can be posted through the SWI register; a hardware
// interrupt always wins when both are available in IDLE.
//
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active low
//   bus  : int_seq_if.slave (bus, controller and core handshakes)
//
// Register map (word addresses):
//   0 CTRL  : [0] en, [15:8] gap
//   1 VBASE : [AW-1:0] vector base
//   2 STAT  : [1:0] state, [4:2] cur_num, [5] sw_pend, [15:8] irq_cnt
//             (read-only; any write clears irq_cnt)
//   3 SWI   : write posts a software interrupt with number din[2:0]
//   other   : read 0, writes ignored
// -----------------------------------------------------------------------------
module int_seq #(
   parameter int DW = 16,
   parameter int AW = 13
) (
   input  logic    clk,
   input  logic    rst,
   int_seq_if.slave bus
);

   // State codes are the values software reads back in STAT[1:0].
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACT  = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam logic [AW-1:0] A_CTRL  = AW'(2'd0);
   localparam logic [AW-1:0] A_VBASE = AW'(2'd1);
   localparam logic [AW-1:0] A_STAT  = AW'(2'd2);
   localparam logic [AW-1:0] A_SWI   = AW'(2'd3);

   state_t        state;
   logic          en;
   logic [7:0]    gap;
   logic [7:0]    gap_cnt;
   logic [7:0]    irq_cnt;
   logic [AW-1:0] vbase;
   logic          sw_pend;
   logic [2:0]    sw_num;
   logic [2:0]    cur_num;
   logic          irq_req;
   logic [AW-1:0] irq_vec;
   logic [DW-1:0] dout;
   logic [DW-1:0] rd_data;

   // Handler address: four words per vector, wrapping within AW bits.
   function automatic logic [AW-1:0] vec_of(input logic [AW-1:0] base,
                                            input logic [2:0]    num);
      vec_of = base + {{(AW-5){1'b0}}, num, 2'b00};
   endfunction

   // Read multiplexer; the value is captured into dout on the next edge.
   always_comb begin
      rd_data = {DW{1'b0}};
      case (bus.addr)
         A_CTRL: begin
            rd_data[0]    = en;
            rd_data[15:8] = gap;
         end
         A_VBASE: begin
            rd_data[AW-1:0] = vbase;
         end
         A_STAT: begin
            rd_data[1:0]  = state;
            rd_data[4:2]  = cur_num;
            rd_data[5]    = sw_pend;
            rd_data[15:8] = irq_cnt;
         end
         default: begin
            rd_data = {DW{1'b0}};
         end
      endcase
   end

   // Sequencer FSM, register file and registered outputs.
   // The FSM acts on the register values from before this edge (so a CTRL
   // write racing an accept uses the old en, and a reti racing a CTRL write
   // uses the old gap). Bus writes are applied afterwards so that a STAT
   // write beats the irq_cnt increment and a SWI write re-arms sw_pend even
   // when the pending software request is being taken in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         en      <= 1'b0;
         gap     <= 8'd0;
         gap_cnt <= 8'd0;
         irq_cnt <= 8'd0;
         vbase   <= {AW{1'b0}};
         sw_pend <= 1'b0;
         sw_num  <= 3'd0;
         cur_num <= 3'd0;
         irq_req <= 1'b0;
         irq_vec <= {AW{1'b0}};
         dout    <= {DW{1'b0}};
      end else begin
         if (!bus.we) begin
            dout <= rd_data;
         end

         case (state)
            IDLE: begin
               if (en && bus.int_vld) begin
                  cur_num <= bus.int_num;
                  irq_vec <= vec_of(vbase, bus.int_num);
                  irq_req <= 1'b1;
                  state   <= REQ;
               end else if (en && sw_pend) begin
                  cur_num <= sw_num;
                  irq_vec <= vec_of(vbase, sw_num);
                  irq_req <= 1'b1;
                  sw_pend <= 1'b0;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (bus.irq_ack) begin
                  irq_req <= 1'b0;
                  irq_cnt <= irq_cnt + 8'd1;
                  state   <= ACT;
               end
            end
            ACT: begin
               if (bus.reti) begin
                  if (gap == 8'd0) begin
                     state <= IDLE;
                  end else begin
                     gap_cnt <= gap;
                     state   <= GAP;
                  end
               end
            end
            GAP: begin
               // Leaving on a count of 1 keeps the state in GAP for exactly
               // gap cycles; <= also covers a count that was never loaded.
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt <= 8'd1) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (bus.we) begin
            case (bus.addr)
               A_CTRL: begin
                  en  <= bus.din[0];
                  gap <= bus.din[15:8];
               end
               A_VBASE: begin
                  vbase <= bus.din[AW-1:0];
               end
               A_STAT: begin
                  irq_cnt <= 8'd0;
               end
               A_SWI: begin
                  sw_pend <= 1'b1;
                  sw_num  <= bus.din[2:0];
               end
               default: begin
               end
            endcase
         end
      end
   end

   // int_rdy is a pure function of registers, so it never depends on inputs.
   assign bus.int_rdy = en & (state == IDLE);
   assign bus.irq_req = irq_req;
   assign bus.irq_vec = irq_vec;
   assign bus.dout    = dout;

endmodule

// File: tb/tb_int_seq.sv
// -----------------------------------------------------------------------------
// tb_int_seq
// Self-checking bench for int_seq: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level reference
// model. The model tracks the handshake phase as a number and the guard gap
// as an absolute edge index at which the sequencer becomes idle again.
// -----------------------------------------------------------------------------
module tb_int_seq;

   localparam int DW = 16;
   localparam int AW = 13;

   logic clk = 1'b0;
   logic rst;

   int_seq_if #(.DW(DW), .AW(AW)) bus ();

   int_seq #(.DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   int m_phase;    // 0 idle, 1 request, 2 active, 3 guard gap
   int m_en, m_gap, m_vbase, m_swp, m_swn, m_cur, m_cnt;
   int m_req, m_vec, m_dout;
   int m_idle_at;
   int edge_no = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
   endtask

   task automatic model_reset();
      m_phase = 0; m_en = 0; m_gap = 0; m_vbase = 0; m_swp = 0; m_swn = 0;
      m_cur = 0; m_cnt = 0; m_req = 0; m_vec = 0; m_dout = 0; m_idle_at = 0;
   endtask

   task automatic model_serve(input int n);
      m_cur   = n;
      m_vec   = (m_vbase + 4 * n) % 8192;
      m_req   = 1;
      m_phase = 1;
   endtask

   task automatic model_step(input int r, input int w, input int a, input int d,
                             input int v, input int n, input int k, input int t);
      int rv;
      int ph;
      edge_no++;
      if (r == 0) begin
         model_reset();
      end else begin
         case (a)
            0:       rv = m_gap * 256 + m_en;
            1:       rv = m_vbase;
            2:       rv = m_cnt * 256 + m_swp * 32 + m_cur * 4 + m_phase;
            default: rv = 0;
         endcase
         if (w == 0) m_dout = rv;
         ph = m_phase;
         if (ph == 0) begin
            if (m_en == 1 && v == 1) model_serve(n);
            else if (m_en == 1 && m_swp == 1) begin
               m_swp = 0;
               model_serve(m_swn);
            end
         end else if (ph == 1) begin
            if (k == 1) begin
               m_req   = 0;
               m_phase = 2;
               m_cnt   = (m_cnt + 1) % 256;
            end
         end else if (ph == 2) begin
            if (t == 1) begin
               if (m_gap == 0) m_phase = 0;
               else begin
                  m_phase   = 3;
                  m_idle_at = edge_no + m_gap;
               end
            end
         end else begin
            if (edge_no == m_idle_at) m_phase = 0;
         end
         if (w == 1) begin
            case (a)
               0: begin
                  m_en  = d % 2;
                  m_gap = (d / 256) % 256;
               end
               1: m_vbase = d % 8192;
               2: m_cnt = 0;
               3: begin
                  m_swp = 1;
                  m_swn = d % 8;
               end
               default: ;
            endcase
         end
      end
   endtask

   // One clock: capture inputs, advance model at the edge, compare after it.
   task automatic tick();
      int r, w, a, d, v, n, k, t;
      r = int'(rst);       w = int'(bus.we);      a = int'(bus.addr);
      d = int'(bus.din);   v = int'(bus.int_vld); n = int'(bus.int_num);
      k = int'(bus.irq_ack); t = int'(bus.reti);
      @(posedge clk);
      model_step(r, w, a, d, v, n, k, t);
      #1;
      check("dout",    int'(bus.dout),    m_dout);
      check("int_rdy", int'(bus.int_rdy), (m_en == 1 && m_phase == 0) ? 1 : 0);
      check("irq_req", int'(bus.irq_req), m_req);
      check("irq_vec", int'(bus.irq_vec), m_vec);
   endtask

   task automatic wr(input int a, input int d);
      bus.we   = 1'b1;
      bus.addr = AW'(a);
      bus.din  = DW'(d);
      tick();
      bus.we   = 1'b0;
   endtask

   initial begin
      model_reset();
      rst = 1'b0;
      bus.we = 1'b0; bus.addr = '0; bus.din = '0;
      bus.int_vld = 1'b0; bus.int_num = 3'd0; bus.irq_ack = 1'b0; bus.reti = 1'b0;

      // reset defaults
      tick(); tick();
      check("rst_rdy", int'(bus.int_rdy), 0);
      check("rst_vec", int'(bus.irq_vec), 0);
      rst = 1'b1;

      // first accept: en=1, gap=3, VBASE=0x100, number 5
      wr(0, 'h0301);
      wr(1, 'h0100);
      bus.int_vld = 1'b1; bus.int_num = 3'd5;
      tick();
      bus.int_vld = 1'b0;
      check("t1_req", int'(bus.irq_req), 1);
      check("t1_vec", int'(bus.irq_vec), 'h114);
      check("t1_rdy", int'(bus.int_rdy), 0);

      // full handshake with gap=3
      repeat (3) tick();
      bus.irq_ack = 1'b1; bus.addr = AW'(2);
      tick();
      bus.irq_ack = 1'b0;
      check("t2_req_drop", int'(bus.irq_req), 0);
      check("t2_st_req", int'(bus.dout) % 4, 1);
      tick();
      check("t2_st_act", int'(bus.dout) % 4, 2);
      repeat (9) tick();
      bus.reti = 1'b1;
      tick();
      bus.reti = 1'b0;
      tick();
      check("t2_st_gap", int'(bus.dout) % 4, 3);
      check("t2_rdy_g1", int'(bus.int_rdy), 0);
      tick();
      check("t2_rdy_g2", int'(bus.int_rdy), 0);
      tick();
      check("t2_rdy_back", int'(bus.int_rdy), 1);
      check("t2_cnt", (int'(bus.dout) / 256) % 256, 1);

      // hardware beats a same-cycle SWI write
      wr(0, 'h0001);
      bus.we = 1'b1; bus.addr = AW'(3); bus.din = DW'(2);
      bus.int_vld = 1'b1; bus.int_num = 3'd6;
      tick();
      bus.we = 1'b0; bus.int_vld = 1'b0;
      check("t3_hw_vec", int'(bus.irq_vec), 'h118);
      bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
      bus.reti = 1'b1;    tick(); bus.reti = 1'b0;
      tick();
      check("t3_sw_req", int'(bus.irq_req), 1);
      check("t3_sw_vec", int'(bus.irq_vec), 'h108);
      bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
      bus.reti = 1'b1;    tick(); bus.reti = 1'b0;
      bus.addr = AW'(2);
      tick();
      check("t3_swp_clr", (int'(bus.dout) / 32) % 2, 0);

      // enable gating
      wr(0, 0);
      bus.int_vld = 1'b1; bus.int_num = 3'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_gated", int'(bus.irq_req), 0);
      end
      wr(0, 1);
      check("t4_old_en", int'(bus.irq_req), 0);
      tick();
      check("t4_req", int'(bus.irq_req), 1);
      check("t4_vec", int'(bus.irq_vec), 'h10c);

      // disable mid-sequence and stray ack
      bus.int_vld = 1'b0;
      bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
      wr(0, 0);
      bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
      bus.reti = 1'b1;    tick(); bus.reti = 1'b0;
      bus.int_vld = 1'b1;
      repeat (3) tick();
      check("t5_no_req", int'(bus.irq_req), 0);
      bus.int_vld = 1'b0;

      // reset while active
      wr(0, 1);
      bus.int_vld = 1'b1; bus.int_num = 3'd7; tick(); bus.int_vld = 1'b0;
      bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
      rst = 1'b0; tick(); rst = 1'b1;
      check("t6_req", int'(bus.irq_req), 0);
      check("t6_vec", int'(bus.irq_vec), 0);
      check("t6_dout", int'(bus.dout), 0);
      check("t6_rdy", int'(bus.int_rdy), 0);

      // irq_cnt wrap after 256 interrupts
      wr(0, 1);
      wr(1, 'h40);
      for (int i = 0; i < 256; i++) begin
         bus.int_vld = 1'b1; bus.int_num = 3'(i % 8); tick(); bus.int_vld = 1'b0;
         bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
         bus.reti = 1'b1;    tick(); bus.reti = 1'b0;
      end
      bus.addr = AW'(2);
      tick();
      check("t7_wrap", (int'(bus.dout) / 256) % 256, 0);

      // STAT clear racing an increment
      bus.int_vld = 1'b1; tick(); bus.int_vld = 1'b0;
      bus.irq_ack = 1'b1; bus.we = 1'b1; bus.addr = AW'(2);
      tick();
      bus.irq_ack = 1'b0; bus.we = 1'b0;
      tick();
      check("t7_clr_wins", (int'(bus.dout) / 256) % 256, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 499) != 0);
         bus.we      = ($urandom_range(0, 15) == 0);
         bus.addr    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(4, 8191))
                                                   : AW'($urandom_range(0, 3));
         if (bus.addr == AW'(0))
            bus.din = DW'(($urandom_range(0, 7) == 0 ? $urandom_range(0, 255)
                                                     : $urandom_range(0, 4)) * 256
                          + ($urandom_range(0, 7) != 0 ? 1 : 0));
         else
            bus.din = DW'($urandom);
         bus.int_vld = ($urandom_range(0, 1) == 1);
         bus.int_num = 3'($urandom_range(0, 7));
         bus.irq_ack = ($urandom_range(0, 2) == 0);
         bus.reti    = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/int_seq.md
# int_seq

Interrupt entry sequencer between the interrupt controller and the processor core. Accepts `int_vld`/`int_num` from the interrupt controller through the `int_rdy` handshake and issues a vectored request to the core. It holds off new interrupts until the handler executes a return plus a programmable guard gap. Also supports a software-triggered interrupt and exposes control and status registers on the peripheral data bus.

## Interface
Parameters:
- `DW`, 16, data bus width
- `AW`, 13, address bus width; also the vector width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-low
- `din`  in  DW  bus write data
- `addr`  in  AW  bus address
- `we`  in  1  bus write enable, active high
- `dout`  out  DW  bus read data, registered
- `int_vld`  in  1  interrupt trigger from the interrupt controller
- `int_num`  in  3  interrupt number, valid with `int_vld`
- `int_rdy`  out  1  sequencer can accept an interrupt
- `irq_req`  out  1  vectored request to the core
- `irq_vec`  out  AW  handler address
- `irq_ack`  in  1  core has saved its PC and jumped
- `reti`  in  1  core executed a return-from-interrupt

## Operation
Register map (word addresses):
- 0 `CTRL`:
  - [0] `en`
  - [15:8] `gap`, guard cycles after a return
- 1 `VBASE`: vector base, [AW-1:0]
- 2 `STAT`, read-only:
  - [1:0] state
  - [4:2] current number
  - [5] `sw_pend`
  - [15:8] `irq_cnt`
  - Any write to this address clears `irq_cnt`.
- 3 `SWI`: a write sets `sw_pend` and `sw_num` = din[2:0].
- Other addresses read 0; writes to them are ignored.
- A read returns data on `dout` one cycle after `addr` is presented with `we`=0. `dout` holds its value during writes.

State machine (STAT encoding: IDLE=0, REQ=1, ACT=2, GAP=3):
- **IDLE:**
  - `int_rdy` = `en` & (state==IDLE), combinational from registers.
  - If `en`=1 and `int_vld`=1: latch `cur_num`=`int_num` and go to REQ.
  - Otherwise, if `en`=1 and `sw_pend`=1: latch `cur_num`=`sw_num`, clear `sw_pend`, and go to REQ.
  - Hardware has priority. A software request that loses stays pending.
- **REQ:**
  - `irq_req`=1 and `irq_vec` = `VBASE` + {`cur_num`, 2'b00}, truncated to AW.
  - On `irq_ack`: go to ACT and increment `irq_cnt` (8-bit, wraps 255→0).
- **ACT:**
  - On `reti`: if `gap`=0 go to IDLE, else load `gap_cnt`=`gap` and go to GAP.
- **GAP:**
  - `gap_cnt` decrements each cycle. When `gap_cnt`==1, go to IDLE next cycle.
- `irq_ack` is ignored outside REQ. `reti` is ignored outside ACT.
- `int_vld` is ignored whenever `int_rdy`=0, with no queuing. The controller keeps asserting level-triggered sources.
- Writing `en`=0 only blocks acceptance in IDLE. A sequence already in progress completes normally.
- `irq_vec` is registered on entry to REQ and held until the next entry. Its reset value is 0.

## Timing
- Reset (`rst`=0 at a clock edge) sets all of the following, including when a sequence is in progress:
  - state=IDLE
  - `irq_req`=0, `irq_vec`=0, `dout`=0
  - `CTRL`=0, `VBASE`=0, `irq_cnt`=0
  - `sw_pend`=0, `cur_num`=0
  - `int_rdy`=0, because `en`=0
- Accept: `int_vld` is sampled at edge N with `int_rdy`=1. At N+1, `irq_req`=1, `irq_vec` is valid and `int_rdy`=0. Latency is 1 cycle.
- `irq_req` stays high until the edge that samples `irq_ack`. At the following cycle, `irq_req`=0.
- Return: `reti` is sampled at edge K.
  - With `gap`=G>0: state is GAP for G cycles, and `int_rdy` returns to 1 at K+1+G.
  - With `gap`=0: `int_rdy`=1 at K+1.
- Simultaneous events:
  - A bus write to `en`=0 in the same cycle that `int_vld` is sampled in IDLE: the interrupt is accepted, because the old `en` is used.
  - An `irq_cnt` clear in the same cycle as an increment: the clear wins.
  - A `SWI` write in the same cycle that a pending software request is taken: `sw_pend` stays 1 with the new `sw_num`.
- Back-to-back: a level source still asserted when the sequencer reaches IDLE is accepted in that same IDLE cycle.

## Test plan
- **Reset defaults:** reset, then `en`=1, `VBASE`=0x100, `int_vld`=1 with `int_num`=5 → next cycle `irq_req`=1, `irq_vec`=0x114, `int_rdy`=0.
- **Full handshake:** `gap`=3; assert `irq_ack` 4 cycles after `irq_req` rises, then `reti` 10 cycles later → STAT state goes 1→2→3, `int_rdy`=1 exactly 4 cycles after `reti` is sampled, and `irq_cnt`=1.
- **Hardware/software priority:** write `SWI`=2 in the same cycle that `int_vld` (num 6) is sampled → vector for 6 is served first. After return, vector for 2 is served and `sw_pend` then reads 0.
- **Enable gating:** `en`=0 with `int_vld` held high → `int_rdy`=0 and `irq_req` never rises. Set `en`=1 → `irq_req` rises one cycle later.
- **Disable mid-sequence and stray inputs:** in ACT, write `en`=0 and pulse `irq_ack` → no effect. Then `reti` → state returns to IDLE and no new request is issued.
- **Reset in ACT, and counter wrap:** drive `rst`=0 while in ACT → all outputs take their reset values next cycle. Run 256 acknowledged interrupts → `irq_cnt` reads 0. A `STAT` write in the same cycle as an ack → `irq_cnt` reads 0.
